// File: rtl/aes_round_scheduler_pkg.sv
// Shared types for the AES round scheduler: engine op encodings, FSM states
// and the key-size to round-count mapping.
package aes_round_scheduler_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_INIT  = 2'b01,
    OP_MID   = 2'b10,
    OP_FINAL = 2'b11
  } core_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Returns 0 for an unsupported key size so the caller can reject it.
  function automatic int nr_of(input int key_bits);
    case (key_bits)
      128:     return 10;
      192:     return 12;
      256:     return 14;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_scheduler_if.sv
// Requester-facing and engine-facing signals of the AES round scheduler.
// Handshake: req_valid is held until the one-cycle req_ready pulse accepts it; rsp_valid is a one-cycle completion pulse with no back-pressure.
interface aes_round_scheduler_if
  import aes_round_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GID_W   = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_decrypt;
  logic [NUM_REQ-1:0] req_ready;
  logic [GID_W-1:0]   grant_id;
  logic               busy;
  logic               core_load;
  logic               core_en;
  core_op_t           core_op;
  logic               core_decrypt;
  logic [3:0]         round_idx;
  logic [NUM_REQ-1:0] rsp_valid;
  state_t             dbg_state;

  modport master (
    output req_valid, req_decrypt,
    input  req_ready, grant_id, busy, core_load, core_en, core_op,
           core_decrypt, round_idx, rsp_valid, dbg_state
  );

  modport slave (
    input  req_valid, req_decrypt,
    output req_ready, grant_id, busy, core_load, core_en, core_op,
           core_decrypt, round_idx, rsp_valid, dbg_state
  );

endinterface

// File: rtl/aes_round_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational pick of the first request after the
// stored pointer, with the pointer moved to the winner on advance.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic [IW-1:0] adv_idx,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q;
  logic          found;

  // Reset pointer at N-1 so requester 0 is the first winner.
  always_ff @(posedge clk) begin
    if (reset)        ptr_q <= IW'(N - 1);
    else if (advance) ptr_q <= adv_idx;
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 1; i <= N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (j == ((int'(ptr_q) + i) % N))) begin
          found     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/aes_round_scheduler.sv
// Shares one iterative AES round engine between NUM_REQ requesters, stepping
// it through AddRoundKey, the middle rounds and the final round.
module aes_round_scheduler
  import aes_round_scheduler_pkg::*;
#(
  parameter int KEY_BITS = 192,
  parameter int NUM_REQ  = 2
) (
  input logic             clk,
  input logic             reset,
  input logic             enable,
  aes_round_scheduler_if.slave bus
);

  localparam int         GID_W = $clog2(NUM_REQ);
  localparam int         NR_I  = nr_of(KEY_BITS);
  localparam logic [3:0] NR    = 4'(NR_I);

  if (NR_I == 0) begin : g_bad_key_bits
    $error("aes_round_scheduler: KEY_BITS must be 128, 192 or 256");
  end
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("aes_round_scheduler: NUM_REQ must be at least 2");
  end

  state_t             state_q, state_d;
  logic [3:0]         rnd_q, rnd_d;
  logic [GID_W-1:0]   gid_q, gid_d;
  logic               mode_q, mode_d;
  logic [NUM_REQ-1:0] arb_grant;
  logic [GID_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] owner_oh;

  rr_arbiter #(.N(NUM_REQ), .IW(GID_W)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.req_valid),
    .advance   (state_q == S_INIT),
    .adv_idx   (gid_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign owner_oh      = NUM_REQ'(1) << gid_q;
  assign bus.dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      gid_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      gid_q   <= gid_d;
      mode_q  <= mode_d;
    end
  end

  // With enable low every register simply holds.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    gid_d   = gid_q;
    mode_d  = mode_q;
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (|arb_grant) begin
            state_d = S_INIT;
            gid_d   = arb_idx;
            mode_d  = bus.req_decrypt[arb_idx];
            rnd_d   = 4'd0;
          end
        end
        S_INIT: begin
          state_d = S_ROUND;
          rnd_d   = 4'd1;
        end
        S_ROUND: begin
          if (rnd_q == NR - 4'd1) state_d = S_FINAL;
          else                    rnd_d   = rnd_q + 4'd1;
        end
        S_FINAL: state_d = S_DONE;
        S_DONE: begin
          state_d = S_IDLE;
          rnd_d   = 4'd0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_ready    = '0;
    bus.grant_id     = '0;
    bus.busy         = 1'b0;
    bus.core_load    = 1'b0;
    bus.core_en      = 1'b0;
    bus.core_op      = OP_NONE;
    bus.core_decrypt = 1'b0;
    bus.round_idx    = 4'd0;
    bus.rsp_valid    = '0;
    case (state_q)
      S_INIT: begin
        bus.busy         = 1'b1;
        bus.grant_id     = gid_q;
        bus.req_ready    = enable ? owner_oh : '0;
        bus.core_load    = enable;
        bus.core_en      = enable;
        bus.core_op      = OP_INIT;
        bus.core_decrypt = mode_q;
        bus.round_idx    = mode_q ? NR : 4'd0;
      end
      S_ROUND: begin
        bus.busy         = 1'b1;
        bus.grant_id     = gid_q;
        bus.core_en      = enable;
        bus.core_op      = OP_MID;
        bus.core_decrypt = mode_q;
        bus.round_idx    = mode_q ? (NR - rnd_q) : rnd_q;
      end
      S_FINAL: begin
        bus.busy         = 1'b1;
        bus.grant_id     = gid_q;
        bus.core_en      = enable;
        bus.core_op      = OP_FINAL;
        bus.core_decrypt = mode_q;
        bus.round_idx    = mode_q ? 4'd0 : NR;
      end
      S_DONE: begin
        bus.busy      = 1'b1;
        bus.grant_id  = gid_q;
        bus.rsp_valid = enable ? owner_oh : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/aes_round_scheduler.md
Name: aes_round_scheduler

Overview:
- Controller that shares one iterative AES round engine (state register, round function and expanded-key RAM, all external) between NUM_REQ requesters.
- Arbitrates round-robin and sequences the engine through initial AddRoundKey, Nr-1 middle rounds and the final round for encrypt or decrypt.
- Drives the key-index and op-select lines only; no data passes through this block.
- Sits between the requester front-ends and the AESmaster-style datapath.

Parameters:
- KEY_BITS, 192, AES key size: 128, 192 or 256. Any other value is an elaboration error.
- NUM_REQ, 2, number of requesters (>=2). GID_W = $clog2(NUM_REQ).
- Derived NR: 10, 12 or 14 for KEY_BITS 128, 192 or 256.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  global run enable; freezes the scheduler when 0
- req_valid  in  NUM_REQ  per-requester request; held until accepted
- req_decrypt  in  NUM_REQ  per-requester mode (1 = decrypt), sampled at grant
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
- grant_id  out  GID_W  index of the owning requester; valid while busy
- busy  out  1  an operation is in flight
- core_load  out  1  engine loads the selected requester's input block (grant cycle)
- core_en  out  1  engine state register update strobe
- core_op  out  2  00 NONE, 01 INIT (AddRoundKey only), 10 MID (full round), 11 FINAL (no MixColumns)
- core_decrypt  out  1  engine applies inverse round
- round_idx  out  4  expanded-key word-group index to read this cycle
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner

Behaviour:
- Reset values: all outputs 0; state IDLE; round counter 0; last_grant = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- Registered outputs: each state's outputs are asserted in the cycle the FSM is in that state.
- IDLE:
  - Outputs: core_op = NONE, core_en = 0, busy = 0.
  - If enable = 1 and any req_valid bit is set: pick g = first set bit searching from last_grant+1 with wrap-around.
  - Next cycle enters INIT with req_ready[g] = 1, grant_id = g, and the mode latched from req_decrypt[g].
- INIT (grant cycle):
  - Outputs: core_load = 1, core_en = 1, core_op = INIT, busy = 1.
  - round_idx = 0 for encrypt, NR for decrypt.
  - Updates last_grant = g.
- ROUND, r = 1..NR-1, one cycle each:
  - Outputs: core_en = 1, core_op = MID.
  - round_idx = r for encrypt, NR-r for decrypt.
- FINAL:
  - Outputs: core_en = 1, core_op = FINAL.
  - round_idx = NR for encrypt, 0 for decrypt.
- DONE: rsp_valid[g] = 1 for exactly one cycle, busy = 1; next state is IDLE.
- Latency and throughput:
  - rsp_valid occurs NR+1 cycles after req_ready.
  - A pending request is granted on the cycle after DONE, so the minimum grant spacing is NR+3 cycles.
- core_decrypt equals the latched mode from INIT through FINAL; otherwise 0.
- enable = 0 in any non-IDLE state:
  - State, counter and grant_id hold.
  - core_en, core_load, req_ready and rsp_valid are forced to 0.
  - round_idx and core_op hold their values.
  - The pending rsp_valid is emitted when enable returns; nothing is lost or duplicated.
- enable = 0 in IDLE: no grant.
- Requester drops req_valid before req_ready: no grant, no error.
- A requester is never granted twice without its rsp_valid in between.
- Simultaneous requests: round-robin fairness; with all requesters valid, grants rotate 0,1,...,NUM_REQ-1,0.
- reset asserted in any state:
  - Next cycle IDLE with all outputs 0; the in-flight op is discarded with no rsp_valid.
  - last_grant returns to NUM_REQ-1.
- Round counter is 4 bits; NR <= 14 so it never wraps.

Decomposition:
- aes_pkg holds:
  - function nr_of(KEY_BITS) returning 10/12/14;
  - core_op encodings OP_NONE/OP_INIT/OP_MID/OP_FINAL;
  - FSM state enum.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, a last_grant pointer, an advance strobe.
  - Outputs: one-hot grant and binary index, combinational.
  - Pointer register lives inside, updated on advance.

Test Plan:
- KEY_BITS=192, reset, then req_valid=01, req_decrypt=0:
  - req_ready=01 at T; round_idx 0,1,...,11,12 at T..T+12;
  - core_op INIT, MID x11, FINAL; rsp_valid=01 at T+13;
  - external engine output equals 128'hdda97ca4864cdfe06eaf70a0ec0d7191.
- Same with req_decrypt=1 and the ciphertext as input: round_idx 12,11,...,1,0; core_decrypt=1 T..T+12; result 128'h00112233445566778899aabbccddeeff.
- req_valid=11 held from reset:
  - req_ready=01 at T, rsp_valid=01 at T+13;
  - req_ready=10 at T+15, rsp_valid=10 at T+28;
  - third grant goes to requester 0.
- enable=0 for 3 cycles while round_idx=5:
  - round_idx holds 5 and core_en=0 for those cycles;
  - rsp_valid is delayed exactly 3 cycles; ciphertext is unchanged.
- reset pulse at round_idx=7:
  - next cycle busy=0 and all outputs 0; no rsp_valid;
  - a new req_valid=10 grants requester 1 and restarts at round_idx 0.
- KEY_BITS=128 and 256 builds: rsp_valid at T+11 and T+15; outputs match 69c4e0d8...c55a and 8ea2b7ca...6089.
